// File: rtl/switch_allocator_if.sv
// Switch allocator types and request/grant interface.
// Optional feature macro: SA_DROP_CNT_EN adds the drop_cnt counter output.
package switch_allocator_pkg;
  localparam int unsigned N_PORTS = 7;
  localparam int unsigned SEL_W   = 3;

  // Output port identifiers; DROP discards the flit without using the crossbar
  typedef enum logic [SEL_W-1:0] {
    LOCAL, EAST, WEST, NORTH, SOUTH, UP, DOWN, DROP
  } port_t;
endpackage

interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic [N_PORTS-1:0]            req_valid;
  port_t [N_PORTS-1:0]           req_port;
  logic [N_PORTS-1:0]            req_tail;
  logic [N_PORTS-1:0]            out_ready;
  logic [N_PORTS-1:0]            grant;
  logic [N_PORTS-1:0]            xbar_valid;
  logic [N_PORTS-1:0][SEL_W-1:0] xbar_sel;
  logic                          proto_err;
`ifdef SA_DROP_CNT_EN
  logic [15:0]                   drop_cnt;

  modport master (
    output req_valid, req_port, req_tail, out_ready,
    input  grant, xbar_valid, xbar_sel, proto_err, drop_cnt
  );
  modport slave (
    input  req_valid, req_port, req_tail, out_ready,
    output grant, xbar_valid, xbar_sel, proto_err, drop_cnt
  );
`else
  modport master (
    output req_valid, req_port, req_tail, out_ready,
    input  grant, xbar_valid, xbar_sel, proto_err
  );
  modport slave (
    input  req_valid, req_port, req_tail, out_ready,
    output grant, xbar_valid, xbar_sel, proto_err
  );
`endif
endinterface

// File: rtl/switch_allocator.sv
// Per-router output allocator: round-robin per output, wormhole lock head..tail,
// zero-latency grants. Optional macro SA_DROP_CNT_EN adds a saturating drop counter.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave sa
);

  typedef enum logic {ST_IDLE, ST_LOCKED} out_st_t;

  out_st_t                       st_q    [N_PORTS];
  out_st_t                       st_d    [N_PORTS];
  logic [SEL_W-1:0]              owner_q [N_PORTS];
  logic [SEL_W-1:0]              owner_d [N_PORTS];
  logic [SEL_W-1:0]              rr_q    [N_PORTS];
  logic [SEL_W-1:0]              rr_d    [N_PORTS];
  logic                          proto_err_q;
  logic                          err_set;
  logic [N_PORTS-1:0]            grant_c;
  logic [N_PORTS-1:0]            xv_c;
  logic [N_PORTS-1:0][SEL_W-1:0] sel_c;
  logic [N_PORTS-1:0]            blocked;
  logic                          found;
  logic [SEL_W-1:0]              idx;

  // Per-output lock/pointer state; reset abandons any packet in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < N_PORTS; o++) begin
        st_q[o]    <= ST_IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= SEL_W'(N_PORTS - 1);
      end
      proto_err_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      proto_err_q <= proto_err_q | err_set;
    end
  end

  // Arbitration, lock transitions and crossbar selects
  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    grant_c = '0;
    xv_c    = '0;
    sel_c   = '0;
    blocked = '0;
    err_set = 1'b0;
    found   = 1'b0;
    idx     = '0;

    // DROP flits bypass arbitration and credit
    for (int i = 0; i < N_PORTS; i++) begin
      if (sa.req_valid[i] && sa.req_port[i] == DROP) grant_c[i] = 1'b1;
    end

    // A lock owner that redirects mid-packet is a protocol error and gets nothing
    for (int o = 0; o < N_PORTS; o++) begin
      if (st_q[o] == ST_LOCKED && sa.req_valid[owner_q[o]] &&
          sa.req_port[owner_q[o]] != DROP && sa.req_port[owner_q[o]] != SEL_W'(o)) begin
        blocked[owner_q[o]] = 1'b1;
        err_set             = 1'b1;
      end
    end

    for (int o = 0; o < N_PORTS; o++) begin
      if (st_q[o] == ST_LOCKED) begin
        if (sa.req_valid[owner_q[o]] && sa.req_port[owner_q[o]] == SEL_W'(o) &&
            sa.out_ready[o]) begin
          grant_c[owner_q[o]] = 1'b1;
          xv_c[o]             = 1'b1;
          sel_c[o]            = owner_q[o];
          if (sa.req_tail[owner_q[o]]) st_d[o] = ST_IDLE;
        end
      end else if (sa.out_ready[o]) begin
        found = 1'b0;
        for (int j = 1; j <= N_PORTS; j++) begin
          idx = SEL_W'((32'(rr_q[o]) + 32'(j)) % N_PORTS);
          if (!found && sa.req_valid[idx] && sa.req_port[idx] == SEL_W'(o) && !blocked[idx]) begin
            found        = 1'b1;
            grant_c[idx] = 1'b1;
            xv_c[o]      = 1'b1;
            sel_c[o]     = idx;
            rr_d[o]      = idx;
            if (!sa.req_tail[idx]) begin
              st_d[o]    = ST_LOCKED;
              owner_d[o] = idx;
            end
          end
        end
      end
    end
  end

  assign sa.grant      = rst ? '0 : grant_c;
  assign sa.xbar_valid = rst ? '0 : xv_c;
  assign sa.xbar_sel   = rst ? '0 : sel_c;
  assign sa.proto_err  = proto_err_q;

`ifdef SA_DROP_CNT_EN
  logic [3:0]  drop_n;
  logic [16:0] drop_sum;
  logic [15:0] drop_cnt_q;

  // Number of DROP flits granted this cycle
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (sa.req_valid[i] && sa.req_port[i] == DROP) drop_n = drop_n + 4'd1;
    end
    drop_sum = 17'(drop_cnt_q) + 17'(drop_n);
  end

  // Saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign sa.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed table, corner sequences, random vs model.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_if sa_if();
  switch_allocator dut (.clk(clk), .rst(rst), .sa(sa_if));

  int checks = 0;
  int failures = 0;

  // Reference model: owner -1 means output free; last is previous head winner
  int m_owner [N_PORTS];
  int m_last  [N_PORTS];
  bit m_err;
  int m_drops;
  int n_owner [N_PORTS];
  int n_last  [N_PORTS];
  bit n_err;
  int n_drops;
  logic [N_PORTS-1:0]            m_grant;
  logic [N_PORTS-1:0]            m_xv;
  logic [N_PORTS-1:0][SEL_W-1:0] m_sel;

  typedef struct {
    int         a_in;  port_t a_port; bit a_tail;
    int         b_in;  port_t b_port; bit b_tail;
    logic [6:0] rdy;
    logic [6:0] eg;
    logic [6:0] exv;
    int         so;
    int         es;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    int vld [N_PORTS];
    int prt [N_PORTS];
    int tl  [N_PORTS];
    bit stalled [N_PORTS];
    int q[$];
    int best, bestd, d, k;
    m_grant = '0;
    m_xv    = '0;
    m_sel   = '0;
    if (rst) begin
      foreach (m_owner[o]) begin m_owner[o] = -1; m_last[o] = N_PORTS - 1; end
      m_err = 0;
      m_drops = 0;
    end
    n_owner = m_owner;
    n_last  = m_last;
    n_err   = m_err;
    n_drops = m_drops;
    if (rst) return;
    for (int i = 0; i < N_PORTS; i++) begin
      vld[i] = int'(sa_if.req_valid[i]);
      prt[i] = int'(sa_if.req_port[i]);
      tl[i]  = int'(sa_if.req_tail[i]);
      stalled[i] = 0;
      if (vld[i] != 0 && prt[i] == 7) begin
        m_grant[i] = 1'b1;
        if (n_drops < 65535) n_drops++;
      end
    end
    for (int o = 0; o < N_PORTS; o++) begin
      k = m_owner[o];
      if (k >= 0 && vld[k] != 0 && prt[k] != 7 && prt[k] != o) begin
        stalled[k] = 1;
        n_err = 1;
      end
    end
    for (int o = 0; o < N_PORTS; o++) begin
      k = m_owner[o];
      if (k >= 0) begin
        if (vld[k] != 0 && prt[k] == o && sa_if.out_ready[o]) begin
          m_grant[k] = 1'b1; m_xv[o] = 1'b1; m_sel[o] = SEL_W'(k);
          if (tl[k] != 0) n_owner[o] = -1;
        end
      end else if (sa_if.out_ready[o]) begin
        q.delete();
        for (int i = 0; i < N_PORTS; i++)
          if (vld[i] != 0 && prt[i] == o && !stalled[i]) q.push_back(i);
        if (q.size() > 0) begin
          best = -1; bestd = N_PORTS;
          foreach (q[n]) begin
            d = (q[n] - m_last[o] - 1 + 2 * N_PORTS) % N_PORTS;
            if (d < bestd) begin bestd = d; best = q[n]; end
          end
          m_grant[best] = 1'b1; m_xv[o] = 1'b1; m_sel[o] = SEL_W'(best);
          n_last[o] = best;
          if (tl[best] == 0) n_owner[o] = best;
        end
      end
    end
  endfunction

  // Let inputs settle, then compare every output against the model
  task automatic settle();
    #2;
    model_eval();
    chk("model_grant", sa_if.grant, m_grant);
    chk("model_xbar_valid", sa_if.xbar_valid, m_xv);
    chk("model_xbar_sel", sa_if.xbar_sel, m_sel);
    chk("model_proto_err", sa_if.proto_err, m_err);
`ifdef SA_DROP_CNT_EN
    chk("model_drop_cnt", sa_if.drop_cnt, m_drops);
`endif
  endtask

  task automatic tick();
    m_owner = n_owner;
    m_last  = n_last;
    m_err   = n_err;
    m_drops = n_drops;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    sa_if.req_valid = '0;
    sa_if.req_tail  = '0;
    sa_if.out_ready = '1;
    for (int i = 0; i < N_PORTS; i++) sa_if.req_port[i] = LOCAL;
  endtask

  task automatic req(input int i, input port_t p, input bit t);
    sa_if.req_valid[i] = 1'b1;
    sa_if.req_port[i]  = p;
    sa_if.req_tail[i]  = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle();
    chk("rst_grant", sa_if.grant, 0);
    chk("rst_xbar_valid", sa_if.xbar_valid, 0);
    chk("rst_proto_err", sa_if.proto_err, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_req();
    req(3, LOCAL, 1'b1);
    do_reset();

    // Directed table: round-robin on UP, 3-flit wormhole on LOCAL, parallel outputs, DROP
    vecs[0] = '{1, UP,    1'b1, 2, UP,    1'b1, 7'h7F, 7'b0000010, 7'b0100000, 5, 1};
    vecs[1] = '{1, UP,    1'b1, 2, UP,    1'b1, 7'h7F, 7'b0000100, 7'b0100000, 5, 2};
    vecs[2] = '{3, LOCAL, 1'b0, -1, LOCAL, 1'b0, 7'h7F, 7'b0001000, 7'b0000001, 0, 3};
    vecs[3] = '{3, LOCAL, 1'b0, 4, LOCAL, 1'b1, 7'h7F, 7'b0001000, 7'b0000001, 0, 3};
    vecs[4] = '{3, LOCAL, 1'b1, 4, LOCAL, 1'b1, 7'h7F, 7'b0001000, 7'b0000001, 0, 3};
    vecs[5] = '{-1, LOCAL, 1'b0, 4, LOCAL, 1'b1, 7'h7F, 7'b0010000, 7'b0000001, 0, 4};
    vecs[6] = '{0, NORTH, 1'b1, 6, SOUTH, 1'b1, 7'h7F, 7'b1000001, 7'b0011000, 3, 0};
    vecs[7] = '{6, DROP,  1'b0, 1, EAST,  1'b1, 7'h00, 7'b1000000, 7'b0000000, 1, 0};
    for (int v = 0; v < 8; v++) begin
      clear_req();
      if (vecs[v].a_in >= 0) req(vecs[v].a_in, vecs[v].a_port, vecs[v].a_tail);
      if (vecs[v].b_in >= 0) req(vecs[v].b_in, vecs[v].b_port, vecs[v].b_tail);
      sa_if.out_ready = vecs[v].rdy;
      settle();
      chk($sformatf("vec%0d_grant", v), sa_if.grant, vecs[v].eg);
      chk($sformatf("vec%0d_xbar_valid", v), sa_if.xbar_valid, vecs[v].exv);
      chk($sformatf("vec%0d_xbar_sel", v), sa_if.xbar_sel[vecs[v].so], vecs[v].es);
      tick();
    end

    // Stall mid-packet: lock kept, same owner resumes
    clear_req();
    do_reset();
    req(5, NORTH, 1'b0);
    settle(); chk("stall_head", sa_if.grant, 7'b0100000); tick();
    for (int c = 0; c < 2; c++) begin
      req(5, NORTH, 1'b0); req(0, NORTH, 1'b1); sa_if.out_ready[NORTH] = 1'b0;
      settle();
      chk("stall_grant", sa_if.grant, 0);
      chk("stall_xbar_valid", sa_if.xbar_valid, 0);
      chk("stall_xbar_sel", sa_if.xbar_sel, 0);
      tick();
    end
    sa_if.out_ready = '1;
    settle(); chk("stall_resume", sa_if.grant, 7'b0100000);
    chk("stall_resume_sel", sa_if.xbar_sel[NORTH], 5); tick();
    req(5, NORTH, 1'b1);
    settle(); chk("stall_tail", sa_if.grant, 7'b0100000); tick();
    clear_req(); req(0, NORTH, 1'b1);
    settle(); chk("stall_next", sa_if.grant, 7'b0000001); tick();

    // All inputs to EAST: strict rotation
    clear_req();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N_PORTS; i++) req(i, EAST, 1'b1);
      settle();
      chk("rotate_grant", sa_if.grant, 1 << (c % 7));
      chk("rotate_sel", sa_if.xbar_sel[EAST], c % 7);
      tick();
    end

    // DROP ignores credit and crossbar
    clear_req();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req(6, DROP, 1'b0); sa_if.out_ready = '0;
      settle();
      chk("drop_grant", sa_if.grant, 7'b1000000);
      chk("drop_xbar_valid", sa_if.xbar_valid, 0);
      tick();
    end
`ifdef SA_DROP_CNT_EN
    chk("drop_cnt4", sa_if.drop_cnt, 4);
`endif

    // Reset mid-packet, then mid-packet redirection
    clear_req();
    do_reset();
    req(3, WEST, 1'b0);
    settle(); chk("mid_head", sa_if.grant, 7'b0001000); tick();
    req(3, WEST, 1'b0);
    do_reset();
    clear_req(); req(3, WEST, 1'b1); req(1, WEST, 1'b1);
    settle(); chk("post_rst_grant", sa_if.grant, 7'b0000010);
    chk("post_rst_err", sa_if.proto_err, 0); tick();
    clear_req(); req(3, WEST, 1'b1);
    settle(); chk("post_rst_next", sa_if.grant, 7'b0001000); tick();
    clear_req(); req(2, EAST, 1'b0);
    settle(); chk("lock_east", sa_if.grant, 7'b0000100); tick();
    clear_req(); req(2, SOUTH, 1'b1); req(4, EAST, 1'b1);
    settle(); chk("redirect_grant", sa_if.grant, 0);
    chk("redirect_err_pre", sa_if.proto_err, 0); tick();
    clear_req();
    settle(); chk("redirect_err", sa_if.proto_err, 1); tick();

    // Random traffic against the model
    clear_req();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N_PORTS; i++) begin
        sa_if.req_valid[i] = ($urandom_range(0, 9) < 6);
        sa_if.req_port[i]  = port_t'($urandom_range(0, 7));
        sa_if.req_tail[i]  = $urandom_range(0, 1) != 0;
        sa_if.out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      settle();
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
